nv_nvdla_bdma_grp_sched: RTL and testbench

NV_NVDLA_BDMA_GRP_SCHED -- requirements
Module: NV_NVDLA_BDMA_grp_sched

---
 rtl/nv_nvdla_bdma_grp_sched_if.sv | 37 +++
 rtl/nv_nvdla_bdma_grp_sched.sv | 152 +++++++++++++++
 tb/tb_nv_nvdla_bdma_grp_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_bdma_grp_sched_if.sv
// Scheduler-facing bundle: CSB launch/interrupt controls, load launch handshake,
// store completion and status back to CSB.
interface nv_nvdla_bdma_grp_sched_if #(
    parameter int STALL_W = 32
);
    logic               csb2sch_grp0_op_en;
    logic               csb2sch_grp1_op_en;
    logic               csb2sch_grp0_intr;
    logic               csb2sch_grp1_intr;
    logic               csb2sch_stall_clr;
    logic               sch2ld_vld;
    logic               sch2ld_grp;
    logic               ld2sch_rdy;
    logic               st2sch_done;
    logic               sch2csb_grp0_done;
    logic               sch2csb_grp1_done;
    logic [1:0]         sch2glb_done_intr_pd;
    logic [STALL_W-1:0] sch2csb_stall_cnt;
    logic               sch2csb_err;
    logic               sch_idle;

    // Driver side (CSB / load / store engines)
    modport master (
        output csb2sch_grp0_op_en, csb2sch_grp1_op_en, csb2sch_grp0_intr,
               csb2sch_grp1_intr, csb2sch_stall_clr, ld2sch_rdy, st2sch_done,
        input  sch2ld_vld, sch2ld_grp, sch2csb_grp0_done, sch2csb_grp1_done,
               sch2glb_done_intr_pd, sch2csb_stall_cnt, sch2csb_err, sch_idle
    );

    // Scheduler side
    modport slave (
        input  csb2sch_grp0_op_en, csb2sch_grp1_op_en, csb2sch_grp0_intr,
               csb2sch_grp1_intr, csb2sch_stall_clr, ld2sch_rdy, st2sch_done,
        output sch2ld_vld, sch2ld_grp, sch2csb_grp0_done, sch2csb_grp1_done,
               sch2glb_done_intr_pd, sch2csb_stall_cnt, sch2csb_err, sch_idle
    );
endinterface

// File: rtl/nv_nvdla_bdma_grp_sched.sv
// BDMA two-group launch scheduler: strict grp0/grp1 alternation, 2-deep
// in-flight tracking, completion/interrupt pulses, stall counter, sticky error.
module nv_nvdla_bdma_grp_sched #(
    parameter int STALL_W = 32
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    nv_nvdla_bdma_grp_sched_if.slave      sch
);
    typedef enum logic {ST_IDLE, ST_LAUNCH} state_t;

    state_t             r_state;
    logic               r_vld;
    logic               r_grp;
    logic               r_cons;
    logic [1:0]         r_pending;
    logic [1:0]         r_intr_q;
    logic [1:0][1:0]    r_fifo;       // entry = {intr, grp}
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_cnt;
    logic [1:0]         r_done;
    logic [1:0]         r_intr_pd;
    logic [STALL_W-1:0] r_stall;
    logic               r_err;

    logic [1:0] w_op_en;
    logic [1:0] w_intr;
    logic [1:0] w_inflight;
    logic [1:0] w_accept;
    logic [1:0] w_head;
    logic [1:0] w_tail;
    logic       w_empty;
    logic       w_full;
    logic       w_hs;
    logic       w_pop;
    logic       w_reject;

    assign w_op_en  = {sch.csb2sch_grp1_op_en, sch.csb2sch_grp0_op_en};
    assign w_intr   = {sch.csb2sch_grp1_intr,  sch.csb2sch_grp0_intr};
    assign w_empty  = (r_cnt == 2'd0);
    assign w_full   = (r_cnt == 2'd2);
    assign w_hs     = r_vld & sch.ld2sch_rdy;
    assign w_pop    = sch.st2sch_done & ~w_empty;
    assign w_head   = r_fifo[r_rd_ptr];
    assign w_tail   = r_fifo[~r_rd_ptr];

    // A head being popped this edge no longer blocks a relaunch of its group.
    always_comb begin
        w_inflight = 2'b00;
        for (int g = 0; g < 2; g++) begin
            w_inflight[g] = (!w_empty && (w_head[0] == g[0]) && !w_pop) ||
                            (w_full && (w_tail[0] == g[0]));
        end
    end

    assign w_accept = w_op_en & ~r_pending & ~w_inflight;
    assign w_reject = |(w_op_en & ~w_accept);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
            r_grp   <= 1'b0;
            r_cons  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending[r_cons] && !w_full) begin
                        r_state <= ST_LAUNCH;
                        r_vld   <= 1'b1;
                        r_grp   <= r_cons;
                    end
                end
                ST_LAUNCH: begin
                    if (sch.ld2sch_rdy) begin
                        r_state <= ST_IDLE;
                        r_vld   <= 1'b0;
                        r_cons  <= ~r_cons;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_pending <= 2'b00;
            r_intr_q  <= 2'b00;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (w_hs && (r_grp == g[0])) begin
                    r_pending[g] <= 1'b0;
                end else if (w_accept[g]) begin
                    r_pending[g] <= 1'b1;
                    r_intr_q[g]  <= w_intr[g];
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_fifo    <= '0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_cnt     <= 2'd0;
            r_done    <= 2'b00;
            r_intr_pd <= 2'b00;
        end else begin
            if (w_hs) begin
                r_fifo[r_wr_ptr] <= {r_intr_q[r_grp], r_grp};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt     <= r_cnt + {1'b0, w_hs} - {1'b0, w_pop};
            r_done    <= w_pop ? (2'b01 << w_head[0]) : 2'b00;
            r_intr_pd <= (w_pop && w_head[1]) ? (2'b01 << w_head[0]) : 2'b00;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (sch.csb2sch_stall_clr) begin
                r_stall <= '0;
            end else if (r_vld && !sch.ld2sch_rdy && !(&r_stall)) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_reject || (sch.st2sch_done && w_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sch.sch2ld_vld           = r_vld;
    assign sch.sch2ld_grp           = r_grp;
    assign sch.sch2csb_grp0_done    = r_done[0];
    assign sch.sch2csb_grp1_done    = r_done[1];
    assign sch.sch2glb_done_intr_pd = r_intr_pd;
    assign sch.sch2csb_stall_cnt    = r_stall;
    assign sch.sch2csb_err          = r_err;
    assign sch.sch_idle             = (r_state == ST_IDLE) && (r_pending == 2'b00) && w_empty;
endmodule

// File: tb/tb_nv_nvdla_bdma_grp_sched.sv
// Directed bench for the BDMA group scheduler; narrow stall counter so
// saturation is reachable in a few cycles.
module tb_nv_nvdla_bdma_grp_sched;
    localparam int SW = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    nv_nvdla_bdma_grp_sched_if #(.STALL_W(SW)) sif ();

    nv_nvdla_bdma_grp_sched #(.STALL_W(SW)) u_dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .sch             (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_vld"},  32'(sif.sch2ld_vld), 0);
        chk({tag, "_grp"},  32'(sif.sch2ld_grp), 0);
        chk({tag, "_d0"},   32'(sif.sch2csb_grp0_done), 0);
        chk({tag, "_d1"},   32'(sif.sch2csb_grp1_done), 0);
        chk({tag, "_ipd"},  32'(sif.sch2glb_done_intr_pd), 0);
        chk({tag, "_idle"}, 32'(sif.sch_idle), 1);
        chk({tag, "_err"},  32'(sif.sch2csb_err), 0);
        chk({tag, "_stl"},  32'(sif.sch2csb_stall_cnt), 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        sif.csb2sch_grp0_op_en = 1'b0;
        sif.csb2sch_grp1_op_en = 1'b0;
        sif.csb2sch_grp0_intr  = 1'b0;
        sif.csb2sch_grp1_intr  = 1'b0;
        sif.csb2sch_stall_clr  = 1'b0;
        sif.ld2sch_rdy         = 1'b1;
        sif.st2sch_done        = 1'b0;
        do_reset();
        chk_rst("rst");

        // grp0 launch with interrupt, completion 10 cycles after op_en
        sif.csb2sch_grp0_op_en = 1'b1;
        sif.csb2sch_grp0_intr  = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        chk("t1_vld_n1", 32'(sif.sch2ld_vld), 0);
        chk("t1_idle_n1", 32'(sif.sch_idle), 0);
        step();
        chk("t1_vld_n2", 32'(sif.sch2ld_vld), 1);
        chk("t1_grp_n2", 32'(sif.sch2ld_grp), 0);
        step();
        chk("t1_vld_n3", 32'(sif.sch2ld_vld), 0);
        steps(7);
        sif.st2sch_done = 1'b1;
        step();
        sif.st2sch_done = 1'b0;
        chk("t1_d0", 32'(sif.sch2csb_grp0_done), 1);
        chk("t1_d1", 32'(sif.sch2csb_grp1_done), 0);
        chk("t1_ipd", 32'(sif.sch2glb_done_intr_pd), 2'b01);
        // relaunch request in the completion cycle is legal
        sif.csb2sch_grp0_op_en = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        chk("t1_d0_off", 32'(sif.sch2csb_grp0_done), 0);
        chk("t1_ipd_off", 32'(sif.sch2glb_done_intr_pd), 0);
        chk("t1_err", 32'(sif.sch2csb_err), 0);
        chk("t1_pend", 32'(sif.sch_idle), 0);

        // grp1 first: must wait for grp0, then both launch in order
        do_reset();
        sif.csb2sch_grp0_intr  = 1'b0;
        sif.csb2sch_grp1_op_en = 1'b1;
        step();
        sif.csb2sch_grp1_op_en = 1'b0;
        steps(3);
        chk("t2_nolaunch", 32'(sif.sch2ld_vld), 0);
        chk("t2_idle", 32'(sif.sch_idle), 0);
        sif.csb2sch_grp0_op_en = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        step();
        chk("t2_vld_a", 32'(sif.sch2ld_vld), 1);
        chk("t2_grp_a", 32'(sif.sch2ld_grp), 0);
        step();
        chk("t2_gap", 32'(sif.sch2ld_vld), 0);
        step();
        chk("t2_vld_b", 32'(sif.sch2ld_vld), 1);
        chk("t2_grp_b", 32'(sif.sch2ld_grp), 1);
        step();
        sif.st2sch_done = 1'b1;
        step();
        chk("t2_d0", 32'(sif.sch2csb_grp0_done), 1);
        chk("t2_ipd0", 32'(sif.sch2glb_done_intr_pd), 0);
        step();
        sif.st2sch_done = 1'b0;
        chk("t2_d1", 32'(sif.sch2csb_grp1_done), 1);
        chk("t2_d0_off", 32'(sif.sch2csb_grp0_done), 0);
        step();
        chk("t2_idle_end", 32'(sif.sch_idle), 1);
        chk("t2_err", 32'(sif.sch2csb_err), 0);

        // back-pressure, stall count, and a rejected third launch
        do_reset();
        sif.ld2sch_rdy         = 1'b0;
        sif.csb2sch_grp0_intr  = 1'b1;
        sif.csb2sch_grp1_intr  = 1'b1;
        sif.csb2sch_grp0_op_en = 1'b1;
        sif.csb2sch_grp1_op_en = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        sif.csb2sch_grp1_op_en = 1'b0;
        step();
        chk("t3_stl0", 32'(sif.sch2csb_stall_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_vld_hold", 32'(sif.sch2ld_vld), 1);
            chk("t3_grp_hold", 32'(sif.sch2ld_grp), 0);
        end
        chk("t3_stl5", 32'(sif.sch2csb_stall_cnt), 5);
        sif.ld2sch_rdy = 1'b1;
        steps(2);
        chk("t3_grp1", 32'(sif.sch2ld_grp), 1);
        step();
        chk("t3_stl_keep", 32'(sif.sch2csb_stall_cnt), 5);
        chk("t3_err0", 32'(sif.sch2csb_err), 0);
        sif.csb2sch_grp0_op_en = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        chk("t3_err1", 32'(sif.sch2csb_err), 1);
        sif.st2sch_done = 1'b1;
        step();
        chk("t3_ipd0", 32'(sif.sch2glb_done_intr_pd), 2'b01);
        step();
        sif.st2sch_done = 1'b0;
        chk("t3_ipd1", 32'(sif.sch2glb_done_intr_pd), 2'b10);

        // spurious done, stall clear priority, saturation
        do_reset();
        sif.st2sch_done = 1'b1;
        step();
        sif.st2sch_done = 1'b0;
        chk("t4_err", 32'(sif.sch2csb_err), 1);
        chk("t4_d0", 32'(sif.sch2csb_grp0_done), 0);
        chk("t4_d1", 32'(sif.sch2csb_grp1_done), 0);
        chk("t4_ipd", 32'(sif.sch2glb_done_intr_pd), 0);
        sif.ld2sch_rdy         = 1'b0;
        sif.csb2sch_grp0_op_en = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        steps(4);
        chk("t4_stl3", 32'(sif.sch2csb_stall_cnt), 3);
        sif.csb2sch_stall_clr = 1'b1;
        step();
        sif.csb2sch_stall_clr = 1'b0;
        chk("t4_clr", 32'(sif.sch2csb_stall_cnt), 0);
        steps(15);
        chk("t5_max", 32'(sif.sch2csb_stall_cnt), 15);
        steps(3);
        chk("t5_sat", 32'(sif.sch2csb_stall_cnt), 15);
        sif.ld2sch_rdy = 1'b1;
        step();

        // reset with two launches in flight
        do_reset();
        sif.csb2sch_grp0_op_en = 1'b1;
        sif.csb2sch_grp1_op_en = 1'b1;
        step();
        sif.csb2sch_grp0_op_en = 1'b0;
        sif.csb2sch_grp1_op_en = 1'b0;
        steps(4);
        chk("t6_busy", 32'(sif.sch_idle), 0);
        rst_n = 1'b0;
        #1;
        chk_rst("t6_async");
        step();
        rst_n = 1'b1;
        step();
        chk("t6_idle", 32'(sif.sch_idle), 1);
        sif.st2sch_done = 1'b1;
        step();
        sif.st2sch_done = 1'b0;
        chk("t6_err", 32'(sif.sch2csb_err), 1);
        chk("t6_d0", 32'(sif.sch2csb_grp0_done), 0);
        chk("t6_d1", 32'(sif.sch2csb_grp1_done), 0);
        chk("t6_ipd", 32'(sif.sch2glb_done_intr_pd), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
